// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - operand/result handshake bundle for the LEGv8 execute stage
interface alu_exec_stage_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
    logic              cond;
    logic              illegal;
    logic [CNT_W-1:0]  op_count;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, flags, cond, illegal, op_count
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, flags, cond, illegal, op_count
    );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered LEGv8 ALU execute stage with a 2-entry result queue
module alu_exec_stage #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    alu_exec_stage_if.slave bus
);
    localparam int MSB = DATA_W - 1;

    typedef struct packed {
        logic              illegal;
        logic              cond;
        logic [3:0]        flags;
        logic [DATA_W-1:0] result;
    } entry_t;

    entry_t            new_e;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    logic              carry;
    logic              ovf;
    logic              legal;

    always_comb begin
        sum   = '0;
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        legal = 1'b1;
        new_e = '0;
        case (bus.alu_ctrl)
            4'd0: res = bus.op_a & bus.op_b;
            4'd1: res = bus.op_a | bus.op_b;
            4'd2: begin
                sum   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
                res   = sum[MSB:0];
                carry = sum[DATA_W];
                ovf   = (bus.op_a[MSB] == bus.op_b[MSB]) && (res[MSB] != bus.op_a[MSB]);
            end
            4'd6: begin
                // Subtract as A + ~B + 1 so carry-out reads as "no borrow"
                sum   = {1'b0, bus.op_a} + {1'b0, ~bus.op_b} + {{DATA_W{1'b0}}, 1'b1};
                res   = sum[MSB:0];
                carry = sum[DATA_W];
                ovf   = (bus.op_a[MSB] != bus.op_b[MSB]) && (res[MSB] != bus.op_a[MSB]);
            end
            4'd7, 4'd8: res = bus.op_b;
            default: legal = 1'b0;
        endcase

        if (legal) begin
            new_e.result = res;
            new_e.flags  = {res[MSB], (res == '0), carry, ovf};
            if (bus.alu_ctrl == 4'd7) begin
                new_e.cond = (bus.op_b == '0);
            end else if (bus.alu_ctrl == 4'd8) begin
                new_e.cond = (bus.op_b != '0);
            end else begin
                new_e.cond = (res == '0);
            end
        end else begin
            new_e.illegal = 1'b1;
        end
    end

    entry_t           mem_q [2];
    entry_t           last_q;
    entry_t           head;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] op_count_d;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        op_count_d = op_count_q;
        if (push && (op_count_q != {CNT_W{1'b1}})) begin
            op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            op_count_q <= '0;
            last_q     <= '0;
        end else begin
            count_q    <= count_d;
            op_count_q <= op_count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Shadow of the visible head so an empty queue keeps showing the last result
            if (out_valid) begin
                last_q <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_e;
        end
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : last_q;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = head.result;
    assign bus.flags     = head.flags;
    assign bus.cond      = head.cond;
    assign bus.illegal   = head.illegal;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - vector table, handshake sequences and random streaming against a model
module tb_alu_exec_stage;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   exp_cnt;

    alu_exec_stage_if #(.DATA_W(64), .CNT_W(16)) bif ();
    alu_exec_stage_if #(.DATA_W(64), .CNT_W(4))  sif ();

    alu_exec_stage #(.DATA_W(64), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    alu_exec_stage #(.DATA_W(64), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  flags;
        logic        cond;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  flags;
        logic        cond;
        logic        ill;
    } vec_t;

    vec_t vt [11];
    exp_t mq [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: unbounded arithmetic, signed overflow judged against the true mathematical value
    function automatic exp_t model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        exp_t                e;
        logic [64:0]         wide;
        logic signed [65:0]  sa;
        logic signed [65:0]  sb;
        logic signed [65:0]  true_s;
        logic                cf;
        logic                vf;
        e  = '0;
        cf = 1'b0;
        vf = 1'b0;
        sa = $signed({{2{a[63]}}, a});
        sb = $signed({{2{b[63]}}, b});
        case (c)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: begin
                wide   = {1'b0, a} + {1'b0, b};
                e.res  = wide[63:0];
                cf     = wide[64];
                true_s = sa + sb;
                vf     = (true_s != $signed({{2{e.res[63]}}, e.res}));
            end
            4'd6: begin
                e.res  = a - b;
                cf     = (a >= b);
                true_s = sa - sb;
                vf     = (true_s != $signed({{2{e.res[63]}}, e.res}));
            end
            4'd7, 4'd8: e.res = b;
            default: begin
                e.ill = 1'b1;
                return e;
            end
        endcase
        e.flags = {e.res[63], (e.res == 64'd0), cf, vf};
        if (c == 4'd7)      e.cond = (b == 64'd0);
        else if (c == 4'd8) e.cond = (b != 64'd0);
        else                e.cond = (e.res == 64'd0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        bif.alu_ctrl = c;
        bif.op_a     = a;
        bif.op_b     = b;
    endtask

    task automatic chk_head(input string nm, input exp_t e);
        chk({nm, ".out_valid"}, 64'(bif.out_valid), 64'd1);
        chk({nm, ".result"},    bif.result,         e.res);
        chk({nm, ".flags"},     64'(bif.flags),     64'(e.flags));
        chk({nm, ".cond"},      64'(bif.cond),      64'(e.cond));
        chk({nm, ".illegal"},   64'(bif.illegal),   64'(e.ill));
    endtask

    initial begin
        exp_t e;
        exp_t px;
        exp_t py;
        logic [3:0]  c;
        logic [63:0] a;
        logic [63:0] b;
        logic        acc;
        logic        pp;

        errors  = 0;
        checks  = 0;
        exp_cnt = 0;
        reset   = 1'b1;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        drive(4'd0, 64'd0, 64'd0);
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b0;
        sif.alu_ctrl  = 4'd2;
        sif.op_a      = 64'd1;
        sif.op_b      = 64'd1;

        vt[0]  = '{4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1'b0, 1'b0};
        vt[1]  = '{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1'b1, 1'b0};
        vt[2]  = '{4'd6, 64'd5, 64'd5, 64'd0, 4'b0110, 1'b1, 1'b0};
        vt[3]  = '{4'd6, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0, 1'b0};
        vt[4]  = '{4'd0, 64'hF0, 64'h3C, 64'h30, 4'b0000, 1'b0, 1'b0};
        vt[5]  = '{4'd1, 64'hF0, 64'h3C, 64'hFC, 4'b0000, 1'b0, 1'b0};
        vt[6]  = '{4'd7, 64'h123, 64'd0, 64'd0, 4'b0100, 1'b1, 1'b0};
        vt[7]  = '{4'd8, 64'h123, 64'd0, 64'd0, 4'b0100, 1'b0, 1'b0};
        vt[8]  = '{4'd8, 64'd0, 64'd4, 64'd4, 4'b0000, 1'b1, 1'b0};
        vt[9]  = '{4'd5, 64'd7, 64'd9, 64'd0, 4'b0000, 1'b0, 1'b1};
        vt[10] = '{4'd15, 64'hFF, 64'hFF, 64'd0, 4'b0000, 1'b0, 1'b1};

        #12;
        chk("rst.out_valid", 64'(bif.out_valid), 64'd0);
        chk("rst.in_ready",  64'(bif.in_ready),  64'd1);
        chk("rst.op_count",  64'(bif.op_count),  64'd0);
        chk("rst.result",    bif.result,         64'd0);
        chk("rst.flags",     64'(bif.flags),     64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].ctrl, vt[i].a, vt[i].b);
            bif.in_valid  = 1'b1;
            bif.out_ready = 1'b0;
            tick();
            bif.in_valid = 1'b0;
            exp_cnt++;
            e = '{vt[i].res, vt[i].flags, vt[i].cond, vt[i].ill};
            chk_head($sformatf("vec%0d", i), e);
            chk($sformatf("vec%0d.op_count", i), 64'(bif.op_count), 64'(exp_cnt));
            bif.out_ready = 1'b1;
            tick();
            bif.out_ready = 1'b0;
            chk($sformatf("vec%0d.drained", i), 64'(bif.out_valid), 64'd0);
            chk($sformatf("vec%0d.hold", i), bif.result, vt[i].res);
        end

        // Backpressure: two pushes fill the queue, a third is refused
        px = model(4'd2, 64'd1, 64'd2);
        py = model(4'd1, 64'd10, 64'd20);
        drive(4'd2, 64'd1, 64'd2);
        bif.in_valid = 1'b1;
        tick();
        chk("bp.in_ready1", 64'(bif.in_ready), 64'd1);
        drive(4'd1, 64'd10, 64'd20);
        tick();
        exp_cnt += 2;
        chk("bp.in_ready2", 64'(bif.in_ready), 64'd0);
        drive(4'd6, 64'd100, 64'd1);
        tick();
        tick();
        chk("bp.refused", 64'(bif.op_count), 64'(exp_cnt));
        chk_head("bp.headX", px);
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        tick();
        chk_head("bp.headY", py);
        chk("bp.in_ready3", 64'(bif.in_ready), 64'd1);
        tick();
        chk("bp.empty", 64'(bif.out_valid), 64'd0);
        chk("bp.hold", bif.result, py.res);
        bif.out_ready = 1'b0;

        // Asynchronous reset with a full queue and in_valid high
        bif.in_valid = 1'b1;
        drive(4'd2, 64'd3, 64'd4);
        tick();
        tick();
        chk("ar.full", 64'(bif.in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.out_valid", 64'(bif.out_valid), 64'd0);
        chk("ar.in_ready",  64'(bif.in_ready),  64'd1);
        chk("ar.op_count",  64'(bif.op_count),  64'd0);
        chk("ar.result",    bif.result,         64'd0);
        #1;
        reset = 1'b0;
        exp_cnt = 0;
        drive(4'd6, 64'd50, 64'd8);
        tick();
        bif.in_valid = 1'b0;
        exp_cnt++;
        chk_head("ar.first", model(4'd6, 64'd50, 64'd8));
        chk("ar.count1", 64'(bif.op_count), 64'd1);
        bif.out_ready = 1'b1;
        tick();
        chk("ar.drained", 64'(bif.out_valid), 64'd0);

        // Random streaming with both handshakes always asserted
        mq.delete();
        for (int i = 0; i < 100; i++) begin
            case ($urandom_range(0, 6))
                0: c = 4'd0;
                1: c = 4'd1;
                2: c = 4'd2;
                3: c = 4'd6;
                4: c = 4'd7;
                5: c = 4'd8;
                default: c = 4'($urandom_range(0, 15));
            endcase
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = 64'd0;
                1: b = a;
                2: b = ~a;
                default: b = {$urandom, $urandom};
            endcase
            drive(c, a, b);
            bif.in_valid  = 1'b1;
            bif.out_ready = 1'b1;
            acc = (mq.size() < 2);
            pp  = (mq.size() > 0);
            tick();
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(model(c, a, b));
                exp_cnt++;
            end
            chk($sformatf("st%0d.in_ready", i), 64'(bif.in_ready), 64'(mq.size() < 2));
            chk($sformatf("st%0d.out_valid", i), 64'(bif.out_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) chk_head($sformatf("st%0d", i), mq[0]);
        end
        bif.in_valid = 1'b0;
        tick();
        chk("st.drained", 64'(bif.out_valid), 64'd0);
        chk("st.op_count", 64'(bif.op_count), 64'(exp_cnt));
        bif.out_ready = 1'b0;

        // Saturation on the narrow counter instance
        sif.in_valid  = 1'b1;
        sif.out_ready = 1'b1;
        repeat (15) tick();
        chk("sat.at15", 64'(sif.op_count), 64'd15);
        repeat (5) tick();
        chk("sat.after20", 64'(sif.op_count), 64'd15);
        sif.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage for the LEGv8 datapath, directly downstream of the ALU control unit. It accepts two operands plus the 4-bit ALU control line and performs the operation selected by that line. It produces the result, NZCV flags and a branch-condition bit. Results are buffered in a 2-entry output queue under a valid/ready handshake, so a stalled memory/writeback stage never loses a result.

## Interface
- DATA_W, 64, operand/result width
- CNT_W, 16, width of the saturating accepted-operation counter

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and control valid
- in_ready  out  1  stage can accept a transfer this cycle
- alu_ctrl  in  4  ALU control line: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 pass B (CBZ), 8 pass B (CBNZ/B)
- op_a  in  DATA_W  operand A
- op_b  in  DATA_W  operand B
- out_valid  out  1  head of queue valid
- out_ready  in  1  consumer takes head this cycle
- result  out  DATA_W  head result
- flags  out  4  head NZCV, bit3 N, bit2 Z, bit1 C, bit0 V
- cond  out  1  head branch condition
- illegal  out  1  head was an undefined control code
- op_count  out  CNT_W  accepted operations, saturating

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Arithmetic is computed combinationally from the inputs and written into the queue tail on a transfer in. It is never recomputed from stored values.
- Operation rules:
  - AND (0): result = A & B; C = V = 0.
  - OR (1): result = A | B; C = V = 0.
  - ADD (2): {C, result} = A + B, computed at DATA_W+1 bits; V = (A[msb] == B[msb]) && (result[msb] != A[msb]).
  - SUB (6): {C, result} = A + ~B + 1; C = 1 means no borrow; V = (A[msb] != B[msb]) && (result[msb] != A[msb]).
  - Pass B (7, 8): result = B; C = V = 0.
- For all defined codes: N = result[msb]; Z = (result == 0).
- cond:
  - Code 7: cond = (B == 0).
  - Code 8: cond = (B != 0).
  - All other codes: cond = Z.
- Undefined codes (3, 4, 5, 9–15): result = 0, flags = 0000, cond = 0, illegal = 1. The entry is still queued and counted.
- Queue: 2 entries, circular with wr_ptr, rd_ptr and a registered count (0..2).
  - Outputs are driven from the head entry.
  - When count = 0, out_valid = 0 and result/flags/cond/illegal hold their last values (0 after reset).
- op_count increments on every transfer in and saturates at 2^CNT_W-1. It never wraps.

## Timing
- Latency: an operation accepted at edge k is visible at the head (out_valid = 1) after edge k when the queue was empty. Otherwise it appears behind the older entries in order.
- in_ready = (count != 2). It is derived from registers only, with no combinational path from out_ready or in_valid.
- out_valid = (count != 0), from registers only.
- Count update per edge:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged; the pointers advance and data order is preserved.
  - Count 0: a pop cannot occur.
  - Count 2: a push cannot occur because in_ready = 0. A same-cycle pop frees the slot only for the next cycle.
- Holding rules:
  - in_valid with in_ready = 0: no state change. The upstream stage holds its inputs.
  - out_valid with out_ready = 0: the head is stable until popped.
- Reset (asynchronous, at any time, including mid-transfer):
  - Clears count, both pointers and op_count to 0.
  - Sets result = 0, flags = 0000, cond = 0, illegal = 0.
  - Drives out_valid = 0 and in_ready = 1 immediately.
  - All queued entries are discarded.
  - The first edge after reset deassertion may accept a transfer.

## Test plan
- Reset during traffic: assert reset with count = 2 and in_valid = 1 → out_valid = 0, in_ready = 1 and op_count = 0 with no clock edge; the first post-reset push is the first output.
- ADD overflow/carry: A = 0x7FFF_FFFF_FFFF_FFFF, B = 1, ctrl = 2 → result 0x8000_0000_0000_0000, NZCV = 1001. A = 0xFFFF_FFFF_FFFF_FFFF, B = 1 → result 0, NZCV = 0110, cond = 1.
- SUB/logic: A = 5, B = 5, ctrl = 6 → result 0, NZCV = 0110. A = 3, B = 5, ctrl = 6 → result 0xFFFF_FFFF_FFFF_FFFE, NZCV = 1000. A = 0xF0, B = 0x3C, ctrl 0 → 0x30; ctrl 1 → 0xFC.
- Branch codes/illegal: B = 0 with ctrl 7 → cond = 1; ctrl 8 → cond = 0. B = 4 with ctrl 8 → cond = 1, result 4. ctrl = 5 → result 0, illegal = 1, op_count still increments.
- Backpressure: hold out_ready = 0 and push ops X, Y → in_ready drops to 0 after the second edge; a third in_valid is not accepted; the head stays X. Then out_ready = 1 for 2 cycles → X then Y in order, and in_ready returns to 1 one edge after the first pop.
- Streaming and saturation: in_valid = out_ready = 1 for 100 cycles of random ops → the output matches a reference model in order with 1-cycle latency and count stays 1. With CNT_W = 4, 20 pushes → op_count = 15.
